// File: rtl/pc_sequencer_if.sv
// Fetch / decode / execute handshake bundle for pc_sequencer.
// master: the sequencer side. slave: the memory/decode/execute side.
interface pc_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            exec_done;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_rdata, exec_done, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_rdata, exec_done, redirect, redirect_pc
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, runs the fetch/execute loop over a
// req/ack instruction-memory handshake, and counts retired instructions.
// Optional build macro PC_MISALIGN_TRAP_EN: a misaligned redirect target sends
// the PC to TRAP_VECTOR and pulses trap; otherwise target bits [1:0] are dropped.
module pc_sequencer #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h80)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_sequencer_if.master       bus,
    input  logic                 stall,
    output logic [XLEN-1:0]      pc,
    output logic [31:0]          retired_cnt
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic                 trap
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [31:0]     retired_cnt_q, retired_cnt_d;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] redirect_tgt;
`ifdef PC_MISALIGN_TRAP_EN
    logic            trap_q, trap_d;
`else
    logic            unused_low_bits;
    assign unused_low_bits = ^{bus.redirect_pc[1:0], TRAP_VECTOR[1:0]};
`endif

    assign seq_pc       = pc_q + XLEN'(4);
    assign redirect_tgt = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // Next-state, next-PC and retire bookkeeping for the fetch/execute loop.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        retired_cnt_d = retired_cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                state_d = stall ? HOLD : FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d       = bus.imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                if (bus.exec_done) begin
                    instr_valid_d = 1'b0;
                    retired_cnt_d = retired_cnt_q + 32'd1;
`ifdef PC_MISALIGN_TRAP_EN
                    if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
                        pc_d   = TRAP_VECTOR;
                        trap_d = 1'b1;
                    end else begin
                        pc_d = bus.redirect ? redirect_tgt : seq_pc;
                    end
`else
                    pc_d = bus.redirect ? redirect_tgt : seq_pc;
`endif
                    state_d = stall ? HOLD : FETCH;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            retired_cnt_q <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            retired_cnt_q <= retired_cnt_d;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q        <= trap_d;
`endif
        end
    end

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign pc              = pc_q;
    assign retired_cnt     = retired_cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign trap            = trap_q;
`endif

endmodule
